// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller: state codes and a clog2 helper.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_NOFUND    = 3'b010,
        ST_SHOWPRICE = 3'b011,
        ST_SHOWMONEY = 3'b100,
        ST_VEND      = 3'b101,
        ST_REFUND    = 3'b110,
        ST_SOLDOUT   = 3'b111
    } state_t;

    // Minimum index width for n items; never returns less than 1.
    function automatic int unsigned vend_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for a bank of debounced level keys in the clk_dvid domain.
module key_edge #(
    parameter int unsigned W = 1
) (
    input  logic         clk_dvid,
    input  logic         reset,
    input  logic [W-1:0] key,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] prev;

    always_ff @(posedge clk_dvid) begin
        if (reset) prev <= '0;
        else       prev <= key;
    end

    assign rise_c = key & ~prev;

endmodule

// File: rtl/vend_fsm_multi.sv
// Multi-product vending controller with coin summing, saturation reject, refund and dwell timer.
// Define STOCK_TRACK_EN to add per-product stock counters and the SOLDOUT state.
module vend_fsm_multi
    import vend_pkg::*;
#(
    parameter int unsigned N_PROD  = 4,
    parameter int unsigned N_COIN  = 4,
    parameter int unsigned MONEY_W = 8,
    parameter int unsigned VAL_W   = 4,
    parameter int unsigned DELAY_W = 32,
    parameter int unsigned STOCK_W = 4
) (
    input  logic                            clk_dvid,
    input  logic                            reset,
    input  logic [N_COIN-1:0]               coin_in,
    input  logic [N_COIN*VAL_W-1:0]         coin_val,
    input  logic [N_PROD-1:0]               sel_in,
    input  logic [N_PROD*VAL_W-1:0]         prod_price,
    input  logic                            cancel,
    input  logic [DELAY_W-1:0]              delay,
    output logic [2:0]                      status,
    output logic [MONEY_W-1:0]              current_money,
    output logic [VAL_W-1:0]                price,
    output logic [MONEY_W-1:0]              change,
    output logic [vend_clog2(N_PROD)-1:0]   sel_idx,
    output logic                            coin_reject,
    output logic                            display_hello,
    output logic                            display_price
);

    localparam int unsigned SEL_W = vend_clog2(N_PROD);
    // Headroom so money plus the summed coins can never wrap before the fit test.
    localparam int unsigned SUM_W = MONEY_W + 2;

    state_t               state_q, state_d;
    logic [MONEY_W-1:0]   money_q, money_d;
    logic [VAL_W-1:0]     price_q, price_d;
    logic [MONEY_W-1:0]   change_q, change_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 reject_q, reject_d;
    logic                 hello_q, hello_d;
    logic                 dprice_q, dprice_d;
    logic [DELAY_W-1:0]   dwell_q, dwell_d;

    logic [N_COIN-1:0]    coin_rise_c;
    logic [N_PROD-1:0]    sel_rise_c;
    logic                 cancel_rise_c;
    logic [SEL_W-1:0]     sel_k_c;
    logic [VAL_W-1:0]     sel_price_c;
    logic [SUM_W-1:0]     coin_sum_c;
    logic [SUM_W-1:0]     coin_total_c;
    logic [DELAY_W-1:0]   dwell_last_c;
    logic                 sold_out_c;
`ifdef STOCK_TRACK_EN
    logic                 stock_take_c;
`endif

    key_edge #(.W(N_COIN)) u_coin_edge (
        .clk_dvid (clk_dvid),
        .reset    (reset),
        .key      (coin_in),
        .rise_c   (coin_rise_c)
    );

    key_edge #(.W(N_PROD)) u_sel_edge (
        .clk_dvid (clk_dvid),
        .reset    (reset),
        .key      (sel_in),
        .rise_c   (sel_rise_c)
    );

    key_edge #(.W(1)) u_cancel_edge (
        .clk_dvid (clk_dvid),
        .reset    (reset),
        .key      (cancel),
        .rise_c   (cancel_rise_c)
    );

    // Lowest-index select wins; sum all coins that rose this cycle.
    always_comb begin
        sel_k_c    = '0;
        coin_sum_c = '0;
        for (int i = int'(N_PROD) - 1; i >= 0; i--) begin
            if (sel_rise_c[i]) sel_k_c = SEL_W'(i);
        end
        for (int unsigned i = 0; i < N_COIN; i++) begin
            if (coin_rise_c[i]) coin_sum_c = coin_sum_c + SUM_W'(coin_val[i*VAL_W +: VAL_W]);
        end
    end

    assign sel_price_c  = prod_price[32'(sel_k_c) * VAL_W +: VAL_W];
    assign coin_total_c = coin_sum_c + SUM_W'(money_q);
    assign dwell_last_c = (delay == '0) ? '0 : delay - 1'b1;

`ifdef STOCK_TRACK_EN
    logic [STOCK_W-1:0] stock_q [N_PROD];

    always_ff @(posedge clk_dvid) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_PROD; i++) stock_q[i] <= '1;
        end else if (stock_take_c && stock_q[sel_k_c] != '0) begin
            stock_q[sel_k_c] <= stock_q[sel_k_c] - 1'b1;
        end
    end

    assign sold_out_c = (stock_q[sel_k_c] == '0);
`else
    // Stock tracking compiled out: nothing is ever sold out.
    assign sold_out_c = 1'b0 & (STOCK_W > 0);
`endif

    // State register and all registered outputs.
    always_ff @(posedge clk_dvid) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            money_q  <= '0;
            price_q  <= '0;
            change_q <= '0;
            sel_q    <= '0;
            reject_q <= 1'b0;
            hello_q  <= 1'b1;
            dprice_q <= 1'b0;
            dwell_q  <= '0;
        end else begin
            state_q  <= state_d;
            money_q  <= money_d;
            price_q  <= price_d;
            change_q <= change_d;
            sel_q    <= sel_d;
            reject_q <= reject_d;
            hello_q  <= hello_d;
            dprice_q <= dprice_d;
            dwell_q  <= dwell_d;
        end
    end

    // Next state: dwell timeout first, then events override in priority cancel > select > coin.
    always_comb begin
        state_d  = state_q;
        money_d  = money_q;
        price_d  = price_q;
        change_d = change_q;
        sel_d    = sel_q;
        reject_d = 1'b0;
        dwell_d  = dwell_q;
`ifdef STOCK_TRACK_EN
        stock_take_c = 1'b0;
`endif

        if (state_q != ST_IDLE) begin
            if (dwell_q == dwell_last_c) begin
                dwell_d = '0;
                case (state_q)
                    ST_VEND: begin
                        state_d = ST_SHOWPRICE;
                        price_d = '0;
                    end
                    ST_REFUND: begin
                        state_d  = ST_IDLE;
                        money_d  = '0;
                        change_d = '0;
                    end
                    ST_NOFUND:    state_d = ST_SHOWMONEY;
                    ST_SOLDOUT:   state_d = ST_SHOWMONEY;
                    ST_SHOWMONEY: state_d = ST_SHOWPRICE;
                    ST_SHOWPRICE: state_d = ST_SHOWMONEY;
                    default:      state_d = state_q;
                endcase
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end

        if (cancel_rise_c && state_q != ST_IDLE && state_q != ST_REFUND) begin
            change_d = money_q;
            state_d  = ST_REFUND;
            dwell_d  = '0;
        end else if (|sel_rise_c && state_q != ST_REFUND) begin
            sel_d   = sel_k_c;
            price_d = sel_price_c;
            dwell_d = '0;
            if (sold_out_c) begin
                state_d = ST_SOLDOUT;
            end else if (money_q >= MONEY_W'(sel_price_c)) begin
                money_d = money_q - MONEY_W'(sel_price_c);
                state_d = ST_VEND;
`ifdef STOCK_TRACK_EN
                stock_take_c = 1'b1;
`endif
            end else begin
                state_d = ST_NOFUND;
            end
        end else if (|coin_rise_c && state_q != ST_REFUND) begin
            if (coin_total_c <= SUM_W'({MONEY_W{1'b1}})) begin
                money_d = MONEY_W'(coin_total_c);
                state_d = ST_SHOWMONEY;
                dwell_d = '0;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    // Display flags follow the next state so they register alongside status.
    always_comb begin
        hello_d  = (state_d == ST_IDLE);
        dprice_d = (state_d == ST_NOFUND) || (state_d == ST_SHOWPRICE);
    end

    assign status        = state_q;
    assign current_money = money_q;
    assign price         = price_q;
    assign change        = change_q;
    assign sel_idx       = sel_q;
    assign coin_reject   = reject_q;
    assign display_hello = hello_q;
    assign display_price = dprice_q;

endmodule
